// File: rtl/sm_run_ctrl_pkg.sv
// Shared command opcodes and run-control state encodings for sm_run_ctrl.
// Both the controller and its cycle counter import this package.
package sm_run_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_RUN     = 2'd0,
    OP_HALT    = 2'd1,
    OP_STEP    = 2'd2,
    OP_READREG = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_HALT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STEP    = 2'd2,
    ST_TIMEOUT = 2'd3
  } run_state_e;

  localparam int unsigned CNT_W     = 32;
  localparam int unsigned REG_IDX_W = 5;

endpackage

// File: rtl/sm_run_ctrl_cycle_cnt.sv
// sm_cycle_cnt: saturating count of CPU-enabled cycles plus the limit compare.
// at_limit_o stays high once reached because the caller stops incrementing.
module sm_cycle_cnt
  import sm_run_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = 160
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             at_limit_o
);

  localparam logic [CNT_W-1:0] LIMIT_W = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  // A limit of zero means the timeout is disabled.
  assign at_limit_o = (LIMIT_W != '0) && (cnt_q >= LIMIT_W);

endmodule

// File: rtl/sm_run_ctrl.sv
// sm_run_ctrl: debug run/halt/step controller with register read-back and cycle limit.
// Breakpoint logic is built only when SM_RUN_CTRL_BREAKPOINT_EN is defined.
module sm_run_ctrl
  import sm_run_ctrl_pkg::*;
#(
  parameter int unsigned CYCLE_LIMIT  = 160,
  parameter bit          RUN_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_arg,
  output logic        cpu_en,
  input  logic [31:0] pc,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  output logic [4:0]  reg_addr,
  input  logic [31:0] reg_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        halted,
  output logic        timeout,
  output logic        bp_hit,
  output logic [31:0] cycle_cnt
);

  localparam run_state_e RESET_STATE = RUN_ON_RESET ? ST_RUN : ST_HALT;

  run_state_e           state_q, state_d;
  logic                 bp_hit_q, bp_hit_d;
  logic [REG_IDX_W-1:0] reg_addr_q, reg_addr_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 bp_match;
  logic                 at_limit;
  logic                 cmd_fire;
  cmd_op_e              op;

  assign op        = cmd_op_e'(cmd_op);
  assign cmd_ready = (state_q != ST_STEP) && !rsp_valid_q;
  assign cmd_fire  = cmd_valid && cmd_ready;

`ifdef SM_RUN_CTRL_BREAKPOINT_EN
  logic first_run_q;

  // Suppressing the check on the first RUN cycle lets a resume execute the breakpoint instruction.
  assign bp_match = bp_en && (pc == bp_addr) && !first_run_q && (state_q == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      first_run_q <= RUN_ON_RESET;
    end else begin
      first_run_q <= (state_d == ST_RUN) && (state_q != ST_RUN);
    end
  end
`else
  logic unused_bp;

  assign unused_bp = ^{bp_en, bp_addr, pc};
  assign bp_match  = 1'b0;
`endif

  // Masking with at_limit keeps the count from passing the limit while the FSM moves to TIMEOUT.
  assign cpu_en = !rst && !at_limit &&
                  (((state_q == ST_RUN) && !bp_match) || (state_q == ST_STEP));

  sm_cycle_cnt #(
    .LIMIT (CYCLE_LIMIT)
  ) u_cycle_cnt (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (cpu_en),
    .cnt_o      (cycle_cnt),
    .at_limit_o (at_limit)
  );

  always_comb begin
    state_d     = state_q;
    bp_hit_d    = bp_hit_q;
    reg_addr_d  = reg_addr_q;
    rsp_valid_d = 1'b0;

    if (cmd_fire && (op == OP_READREG)) begin
      reg_addr_d  = cmd_arg;
      rsp_valid_d = 1'b1;
    end
    if (cmd_fire && ((op == OP_RUN) || (op == OP_STEP))) begin
      bp_hit_d = 1'b0;
    end

    if (at_limit) begin
      state_d = ST_TIMEOUT;
    end else if (bp_match) begin
      state_d  = ST_HALT;
      bp_hit_d = 1'b1;
    end else begin
      case (state_q)
        ST_HALT: begin
          if (cmd_fire && (op == OP_RUN)) begin
            state_d = ST_RUN;
          end else if (cmd_fire && (op == OP_STEP)) begin
            state_d = ST_STEP;
          end
        end
        ST_RUN: begin
          if (cmd_fire && (op == OP_HALT)) begin
            state_d = ST_HALT;
          end
        end
        ST_STEP:    state_d = ST_HALT;
        default:    state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      bp_hit_q    <= 1'b0;
      reg_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bp_hit_q    <= bp_hit_d;
      reg_addr_q  <= reg_addr_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign reg_addr  = reg_addr_q;
  assign rsp_valid = rsp_valid_q && !rst;
  assign rsp_data  = rsp_valid ? reg_data : '0;
  assign halted    = (state_q == ST_HALT);
  assign timeout   = at_limit || (state_q == ST_TIMEOUT);
  assign bp_hit    = bp_hit_q;

endmodule
